vector_vector_alu_sat: RTL and testbench

//  Next-generation per-lane vector-vector ALU for the trace filter chain. Combines each incoming vector with an operand vector

---
 rtl/vector_vector_alu_sat.sv | 249 ++++++++++++++++++++++++
 tb/tb_vector_vector_alu_sat.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_vector_alu_sat.sv
// Per-lane vector-vector ALU. Each lane combines vector_in with an operand from a small vector register file,
// with optional signed/saturating arithmetic, per-chain firmware and result caching back into the register file.
module vector_vector_alu_sat #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int VRF_DEPTH          = 8,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter int SIGNED             = 0,
    parameter int SATURATE           = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tracing,
    input  logic                          valid_in,
    input  logic [1:0]                    eof_in,
    input  logic [1:0]                    bof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic                          valid_out,
    output logic [1:0]                    eof_out,
    output logic [1:0]                    bof_out,
    output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
    output logic                          init_done
);

    localparam int W         = DATA_WIDTH;
    localparam int VW        = N * DATA_WIDTH;
    localparam int CW        = $clog2(MAX_CHAINS);
    localparam int AW        = $clog2(VRF_DEPTH);
    localparam int CFG_BYTES = 5 * MAX_CHAINS;
    localparam int BCW       = $clog2(CFG_BYTES + 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx;

    logic [7:0]      fw_op    [MAX_CHAINS];
    logic [AW-1:0]   fw_rd    [MAX_CHAINS];
    logic [7:0]      fw_cond  [MAX_CHAINS];
    logic [7:0]      fw_cache [MAX_CHAINS];
    logic [AW-1:0]   fw_caddr [MAX_CHAINS];

    logic [BCW-1:0]  byte_cnt;
    logic [BCW-1:0]  cfg_field;
    logic [CW-1:0]   cfg_chain;
    logic            cfg_sel, cfg_wr;

    logic [VW-1:0]   vrf [VRF_DEPTH];
    logic [VW-1:0]   vrf_rdata;

    logic            s1_valid;
    logic [1:0]      s1_eof, s1_bof;
    logic [CW-1:0]   s1_chain;
    logic [VW-1:0]   s1_vec;
    logic [AW-1:0]   s1_rd_addr;

    logic            fwd_valid;
    logic [AW-1:0]   fwd_addr;

    logic [7:0]      cur_op, cur_cond;
    logic [AW-1:0]   cache_addr;
    logic            cache_we, cond_ok;
    logic [VW-1:0]   operand, alu_vec, s1_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= (state == ST_RUN);
            if (state == ST_CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_idx == AW'(VRF_DEPTH - 1)) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Firmware bytes arrive field-major: all chains' op bytes first, then rd_addr, and so on.
    assign cfg_chain = byte_cnt[CW-1:0];
    assign cfg_field = byte_cnt >> CW;
    assign cfg_sel   = (configId == 8'(PERSONAL_CONFIG_ID));
    assign cfg_wr    = !tracing && cfg_sel && (byte_cnt != BCW'(CFG_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                fw_op[c]    <= '0;
                fw_rd[c]    <= '0;
                fw_cond[c]  <= '0;
                fw_cache[c] <= '0;
                fw_caddr[c] <= '0;
            end
        end else begin
            if (!cfg_sel)
                byte_cnt <= '0;
            else if (cfg_wr)
                byte_cnt <= byte_cnt + 1'b1;
            if (cfg_wr) begin
                if (cfg_field == BCW'(0))      fw_op[cfg_chain]    <= configData;
                else if (cfg_field == BCW'(1)) fw_rd[cfg_chain]    <= configData[AW-1:0];
                else if (cfg_field == BCW'(2)) fw_cond[cfg_chain]  <= configData;
                else if (cfg_field == BCW'(3)) fw_cache[cfg_chain] <= configData;
                else if (cfg_field == BCW'(4)) fw_caddr[cfg_chain] <= configData[AW-1:0];
            end
        end
    end

    // Register file: cleared one entry per cycle after reset, then written by cached results.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR)
            vrf[clr_idx] <= '0;
        else if (cache_we)
            vrf[cache_addr] <= s1_result;
        vrf_rdata <= vrf[fw_rd[chainId_in]];
    end

    function automatic logic [W-1:0] alu_lane(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]     sum, dif, ds, ad;
        logic [2*W-1:0] prod;
        logic [W-1:0]   umax, smax, smin, r;
        logic           a_lt_b;
        umax   = '1;
        smax   = {1'b0, {(W-1){1'b1}}};
        smin   = {1'b1, {(W-1){1'b0}}};
        sum    = {1'b0, a} + {1'b0, b};
        dif    = {1'b0, a} - {1'b0, b};
        ds     = {a[W-1], a} - {b[W-1], b};
        ad     = ds[W] ? (~ds + 1'b1) : ds;
        prod   = (SIGNED != 0) ? ({{W{a[W-1]}}, a} * {{W{b[W-1]}}, b}) : ({{W{1'b0}}, a} * {{W{1'b0}}, b});
        a_lt_b = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
        case (op)
            8'd1: begin
                r = sum[W-1:0];
                if (SATURATE != 0) begin
                    if (SIGNED != 0) begin
                        if ((a[W-1] == b[W-1]) && (sum[W-1] != a[W-1])) r = a[W-1] ? smin : smax;
                    end else if (sum[W]) r = umax;
                end
            end
            8'd2: begin
                r = prod[W-1:0];
                if (SATURATE != 0) begin
                    if (SIGNED != 0) begin
                        if (!((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]))) r = prod[2*W-1] ? smin : smax;
                    end else if (|prod[2*W-1:W]) r = umax;
                end
            end
            8'd3: r = a_lt_b ? b : a;
            8'd4: begin
                r = dif[W-1:0];
                if (SATURATE != 0) begin
                    if (SIGNED != 0) begin
                        if ((a[W-1] != b[W-1]) && (dif[W-1] != a[W-1])) r = a[W-1] ? smin : smax;
                    end else if (dif[W]) r = '0;
                end
            end
            8'd5: r = a_lt_b ? a : b;
            8'd6: begin
                if (SIGNED != 0) begin
                    r = ad[W-1:0];
                    if ((SATURATE != 0) && (ad[W] || ad[W-1])) r = smax;
                end else begin
                    r = a_lt_b ? (b - a) : (a - b);
                end
            end
            default: r = a;
        endcase
        return r;
    endfunction

    assign cur_op     = fw_op[s1_chain];
    assign cur_cond   = fw_cond[s1_chain];
    assign cache_addr = fw_caddr[s1_chain];
    assign cache_we   = s1_valid && (fw_cache[s1_chain] != 8'd0) && (state == ST_RUN);
    // The previous item's write lands in the VRF after our read was issued, so take it from the output register.
    assign operand    = (fwd_valid && (fwd_addr == s1_rd_addr)) ? vector_out : vrf_rdata;

    always_comb begin
        cond_ok = 1'b0;
        case (cur_cond)
            8'd0: cond_ok = 1'b1;
            8'd1: cond_ok = s1_eof[0];
            8'd2: cond_ok = !s1_eof[0];
            8'd3: cond_ok = s1_bof[0];
            8'd4: cond_ok = !s1_bof[0];
            8'd5: cond_ok = s1_eof[1];
            8'd6: cond_ok = !s1_eof[1];
            8'd7: cond_ok = s1_bof[1];
            8'd8: cond_ok = !s1_bof[1];
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_vec = '0;
        for (int i = 0; i < N; i++)
            alu_vec[i*W +: W] = alu_lane(cur_op, s1_vec[i*W +: W], operand[i*W +: W]);
    end

    assign s1_result = cond_ok ? alu_vec : s1_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_eof      <= '0;
            s1_bof      <= '0;
            s1_chain    <= '0;
            s1_vec      <= '0;
            s1_rd_addr  <= '0;
            vector_out  <= '0;
            valid_out   <= 1'b0;
            eof_out     <= '0;
            bof_out     <= '0;
            chainId_out <= '0;
            fwd_valid   <= 1'b0;
            fwd_addr    <= '0;
        end else begin
            s1_valid    <= valid_in && tracing && init_done;
            s1_eof      <= eof_in;
            s1_bof      <= bof_in;
            s1_chain    <= chainId_in;
            s1_vec      <= vector_in;
            s1_rd_addr  <= fw_rd[chainId_in];
            vector_out  <= s1_result;
            valid_out   <= s1_valid && tracing;
            eof_out     <= s1_eof;
            bof_out     <= s1_bof;
            chainId_out <= s1_chain;
            fwd_valid   <= cache_we;
            fwd_addr    <= cache_addr;
        end
    end

endmodule

// File: tb/tb_vector_vector_alu_sat.sv
// Directed bench for vector_vector_alu_sat: a default 32-bit instance plus three 2-lane 8-bit instances
// (unsigned saturating, signed saturating, unsigned wrapping) sharing the same control and config stream.
module tb_vector_vector_alu_sat;

    logic         clk;
    logic         rst_n;
    logic         tracing;
    logic         valid_in;
    logic [1:0]   eof_in, bof_in;
    logic [1:0]   chainId_in;
    logic [7:0]   configId, configData;
    logic [255:0] vin_main;
    logic [15:0]  vin_us, vin_ss, vin_wr;

    logic [255:0] main_vo;
    logic [15:0]  us_vo, ss_vo, wr_vo;
    logic         main_valid, us_valid, ss_valid, wr_valid;
    logic [1:0]   main_eof, us_eof, ss_eof, wr_eof;
    logic [1:0]   main_bof, us_bof, ss_bof, wr_bof;
    logic [1:0]   main_ch, us_ch, ss_ch, wr_ch;
    logic         main_done, us_done, ss_done, wr_done;

    logic [7:0]   fw [5][4];
    int           total, bad, cnt;

    vector_vector_alu_sat u_main (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData), .vector_in(vin_main),
        .vector_out(main_vo), .valid_out(main_valid), .eof_out(main_eof), .bof_out(main_bof),
        .chainId_out(main_ch), .init_done(main_done)
    );

    vector_vector_alu_sat #(.N(2), .DATA_WIDTH(8), .SIGNED(0), .SATURATE(1)) u_us (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData), .vector_in(vin_us),
        .vector_out(us_vo), .valid_out(us_valid), .eof_out(us_eof), .bof_out(us_bof),
        .chainId_out(us_ch), .init_done(us_done)
    );

    vector_vector_alu_sat #(.N(2), .DATA_WIDTH(8), .SIGNED(1), .SATURATE(1)) u_ss (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData), .vector_in(vin_ss),
        .vector_out(ss_vo), .valid_out(ss_valid), .eof_out(ss_eof), .bof_out(ss_bof),
        .chainId_out(ss_ch), .init_done(ss_done)
    );

    vector_vector_alu_sat #(.N(2), .DATA_WIDTH(8), .SIGNED(0), .SATURATE(0)) u_wr (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData), .vector_in(vin_wr),
        .vector_out(wr_vo), .valid_out(wr_valid), .eof_out(wr_eof), .bof_out(wr_bof),
        .chainId_out(wr_ch), .init_done(wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] mk32(input logic [31:0] v);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = v * (i + 1);
        return r;
    endfunction

    function automatic logic [15:0] mk8(input logic [7:0] v);
        return {v, v};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [1:0] e, input logic [1:0] b,
                                 input logic [31:0] x);
        valid_in   = v;
        chainId_in = ch;
        eof_in     = e;
        bof_in     = b;
        vin_main   = mk32(x);
        vin_us     = mk8(x[7:0]);
        vin_ss     = mk8(x[7:0]);
        vin_wr     = mk8(x[7:0]);
    endtask

    task automatic clearFw;
        for (int f = 0; f < 5; f++)
            for (int c = 0; c < 4; c++) fw[f][c] = 8'h00;
    endtask

    task automatic setChain(input int c, input logic [7:0] op, input logic [7:0] rd, input logic [7:0] cond,
                            input logic [7:0] cache, input logic [7:0] caddr);
        fw[0][c] = op;
        fw[1][c] = rd;
        fw[2][c] = cond;
        fw[3][c] = cache;
        fw[4][c] = caddr;
    endtask

    // Streams the 20-byte image (field-major), optionally preceded by an aborted partial load and followed by spare bytes.
    task automatic sendImage(input int prefix, input int extra);
        valid_in = 1'b0;
        tracing  = 1'b0;
        configId = 8'hFF;
        tick;
        if (prefix > 0) begin
            configId = 8'h00;
            for (int i = 0; i < prefix; i++) begin configData = 8'h02; tick; end
            configId = 8'hFF;
            tick;
        end
        configId = 8'h00;
        for (int i = 0; i < 20; i++) begin configData = fw[i/4][i%4]; tick; end
        for (int i = 0; i < extra; i++) begin configData = 8'h05; tick; end
        configId = 8'hFF;
        tracing  = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        tracing = 1'b0;
        configId = 8'hFF;
        configData = 8'h00;
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 32'd0);
        clearFw;
        repeat (3) tick;

        checkOutput("rst_valid", main_valid, 0);
        checkOutput("rst_vec", main_vo, 0);
        checkOutput("rst_done", main_done, 0);
        checkOutput("rst_flags", {main_eof, main_bof, main_ch}, 0);

        rst_n = 1'b1;
        cnt = 0;
        do begin tick; cnt++; end while (!main_done && cnt < 50);
        checkOutput("init_cycles", cnt, 9);

        // Add from a cleared entry leaves the input unchanged.
        setChain(1, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0);
        sendImage(0, 0);
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd5); tick;
        applyStimulus(1'b0, 2'd1, 2'b00, 2'b00, 32'd0); tick;
        checkOutput("t1_valid", main_valid, 1);
        checkOutput("t1_vec", main_vo, mk32(5));

        // Running accumulation through VRF[2]: forwarding, then a bubble, then a two-ahead read.
        clearFw;
        setChain(1, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2);
        sendImage(0, 0);
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd1); tick;
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd2); tick;
        checkOutput("t2_acc1", main_vo, mk32(1));
        checkOutput("t2_valid1", main_valid, 1);
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd3); tick;
        checkOutput("t2_acc3", main_vo, mk32(3));
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd4); tick;
        checkOutput("t2_acc6", main_vo, mk32(6));
        applyStimulus(1'b0, 2'd1, 2'b00, 2'b00, 32'd100); tick;
        checkOutput("t2_acc10", main_vo, mk32(10));
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd10); tick;
        checkOutput("t2_bubble_valid", main_valid, 0);
        applyStimulus(1'b0, 2'd1, 2'b00, 2'b00, 32'd0); tick;
        checkOutput("t2_acc20", main_vo, mk32(20));
        checkOutput("t2_valid20", main_valid, 1);

        // Conditional add on eof[0]; VRF[2] now holds 20 per lane unit.
        clearFw;
        setChain(1, 8'd1, 8'd2, 8'd1, 8'd0, 8'd0);
        sendImage(0, 0);
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd7); tick;
        applyStimulus(1'b0, 2'd1, 2'b00, 2'b00, 32'd8); tick;
        checkOutput("t4_pass7", main_vo, mk32(7));
        checkOutput("t4_valid7", main_valid, 1);
        applyStimulus(1'b1, 2'd1, 2'b01, 2'b10, 32'd9); tick;
        checkOutput("t4_pass8", main_vo, mk32(8));
        checkOutput("t4_valid8", main_valid, 0);
        applyStimulus(1'b0, 2'd1, 2'b00, 2'b00, 32'd0); tick;
        checkOutput("t4_add9", main_vo, mk32(29));
        checkOutput("t4_valid9", main_valid, 1);
        checkOutput("t4_eof", main_eof, 2'b01);
        checkOutput("t4_bof", main_bof, 2'b10);
        checkOutput("t4_chain", main_ch, 2'd1);

        // Saturating add/mul/sub on 8-bit lanes; chain 2 caches the operand into VRF[5].
        clearFw;
        setChain(2, 8'd0, 8'd0, 8'd0, 8'd1, 8'd5);
        setChain(1, 8'd1, 8'd5, 8'd0, 8'd0, 8'd0);
        setChain(0, 8'd2, 8'd5, 8'd0, 8'd0, 8'd0);
        setChain(3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0);
        sendImage(0, 0);
        applyStimulus(1'b1, 2'd2, 2'b00, 2'b00, 32'd100); tick;
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd200); tick;
        applyStimulus(1'b1, 2'd0, 2'b00, 2'b00, 32'd2); tick;
        checkOutput("t3_add_us", us_vo, mk8(8'd255));
        checkOutput("t3_add_ss", ss_vo, mk8(8'd44));
        checkOutput("t3_add_wr", wr_vo, mk8(8'd44));
        applyStimulus(1'b1, 2'd2, 2'b00, 2'b00, 32'd20); tick;
        checkOutput("t3_mul_us", us_vo, mk8(8'd200));
        checkOutput("t3_mul_ss", ss_vo, mk8(8'd127));
        checkOutput("t3_mul_wr", wr_vo, mk8(8'd200));
        applyStimulus(1'b1, 2'd3, 2'b00, 2'b00, 32'd10); tick;
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 32'd0); tick;
        checkOutput("t3_sub_us", us_vo, mk8(8'd0));
        checkOutput("t3_sub_ss", ss_vo, mk8(8'hF6));
        checkOutput("t3_sub_wr", wr_vo, mk8(8'hF6));

        // Max/min/absdiff against 100, with a = 200 (-56 when signed).
        clearFw;
        setChain(2, 8'd0, 8'd0, 8'd0, 8'd1, 8'd5);
        setChain(0, 8'd3, 8'd5, 8'd0, 8'd0, 8'd0);
        setChain(1, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0);
        setChain(3, 8'd6, 8'd5, 8'd0, 8'd0, 8'd0);
        sendImage(0, 0);
        applyStimulus(1'b1, 2'd2, 2'b00, 2'b00, 32'd100); tick;
        applyStimulus(1'b1, 2'd0, 2'b00, 2'b00, 32'd200); tick;
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd200); tick;
        checkOutput("t3_max_us", us_vo, mk8(8'd200));
        checkOutput("t3_max_ss", ss_vo, mk8(8'd100));
        applyStimulus(1'b1, 2'd3, 2'b00, 2'b00, 32'd200); tick;
        checkOutput("t3_min_us", us_vo, mk8(8'd100));
        checkOutput("t3_min_ss", ss_vo, mk8(8'd200));
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 32'd0); tick;
        checkOutput("t3_abs_us", us_vo, mk8(8'd100));
        checkOutput("t3_abs_ss", ss_vo, mk8(8'd127));
        checkOutput("t3_abs_wr", wr_vo, mk8(8'd100));

        // Aborted partial load, full image, then spare bytes that must be ignored.
        clearFw;
        setChain(1, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0);
        setChain(3, 8'd4, 8'd2, 8'd0, 8'd0, 8'd0);
        sendImage(3, 5);
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd1); tick;
        applyStimulus(1'b1, 2'd3, 2'b00, 2'b00, 32'd25); tick;
        checkOutput("t5_add", main_vo, mk32(21));
        applyStimulus(1'b0, 2'd0, 2'b00, 2'b00, 32'd0); tick;
        checkOutput("t5_sub", main_vo, mk32(5));

        // Asynchronous reset in the middle of a valid stream.
        applyStimulus(1'b1, 2'd1, 2'b00, 2'b00, 32'd9); tick; tick;
        checkOutput("t6_pre_valid", main_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", main_valid, 0);
        checkOutput("t6_async_vec", main_vo, 0);
        checkOutput("t6_async_done", main_done, 0);
        tick;
        rst_n = 1'b1;
        cnt = 0;
        while (!main_done && cnt < 50) begin
            tick;
            cnt++;
            checkOutput("t6_quiet", main_valid, 0);
        end
        checkOutput("t6_done", main_done, 1);
        tick;
        checkOutput("t6_first_edge", main_valid, 0);
        tick;
        checkOutput("t6_resume_valid", main_valid, 1);
        checkOutput("t6_resume_vec", main_vo, mk32(9));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
